pipeline_sequencer: RTL
=======================

# pipeline_sequencer

Stage sequencer and hazard controller for the MIPS 5-stage pipelined CPU. It drives the per-stage reset/enable pairs of the datapath and flushes wrong-path fetches around jumps and branches. It freezes the whole pipeline on multi-cycle memory accesses and computes the EXE operand-forwarding selects. It also provides a debug run/halt/single-step machine with performance counters.

## Interface
Parameters:
- CNT_W, 32, width of cycle_cnt, retire_cnt and stall_cnt.

Ports:
- clk  in  1  main clock.
- rst  in  1  synchronous, active-high reset.
- inst_data_id  in  32  ID-stage instruction; rs = [25:21], rt = [20:16].
- branch_id  in  1  decoder's pc_src_ctrl != PC_NEXT for the ID instruction.
- is_branch_exe, is_branch_mem  in  1 each  jump/branch present in EXE / MEM.
- regw_addr_exe, regw_addr_mem  in  5 each  destination register in EXE / MEM.
- wb_wen_exe, wb_wen_mem  in  1 each  register write enable in EXE / MEM.
- wb_data_src_exe  in  1  1 = EXE instruction is a load (WB_DATA_MEM).
- mem_valid  in  1  MEM stage holds a real instruction.
- mem_ren, mem_wen  in  1 each  data memory access in MEM.
- mem_ack  in  1  data memory completes the access this cycle.
- dbg_halt  in  1  level: request halt.
- dbg_step  in  1  pulse: while halted, advance one cycle.
- if_rst, if_en, id_rst, id_en, exe_rst, exe_en, mem_rst, mem_en, wb_rst, wb_en  out  1 each  stage controls.
- exe_fwd_a_ctrl, exe_fwd_b_ctrl  out  2 each  forward selects for rs / rt.
- halted  out  1  state == HALT.
- cycle_cnt, retire_cnt, stall_cnt  out  CNT_W each  performance counters.

## Operation
- Internal signals:
  - mem_stall = (mem_ren | mem_wen) & ~mem_ack.
  - advance = (state != HALT) & ~mem_stall.
  - branch_pending = branch_id | is_branch_exe | is_branch_mem.
- Stage controls:
  - All *_rst = rst, except id_rst = rst | (advance & branch_pending).
  - id_en = exe_en = mem_en = wb_en = advance & ~rst.
  - if_en = advance & ~rst & (~branch_pending | is_branch_mem).
  - Net effect: the PC holds while a branch is in ID or EXE, then loads the target when the branch is in MEM. The wrong-path fetch is replaced by a bubble each cycle, giving a 3-cycle taken-or-not penalty.
- Freeze policy: mem_stall or HALT freezes all five stages, WB included. WB is never bubbled, because an EXE consumer may be forwarding from it.
- Forwarding (combinational; sampled by the datapath when exe_en = 1). For the rs field, then identically for rt:
  - If the field is 0 → 0 (none).
  - Else if wb_wen_exe & regw_addr_exe == field: 3 (FWD_MEM, load data) when wb_data_src_exe = 1, otherwise 1 (FWD_ALU_EXE).
  - Else if wb_wen_mem & regw_addr_mem == field → 2 (FWD_WB_MEM).
  - Else → 0.
  - A match in EXE has priority over a match in MEM.
- State machine, states RUN, HALT, STEP:
  - RUN: dbg_halt → HALT.
  - HALT: ~dbg_halt → RUN; dbg_halt & dbg_step → STEP; otherwise stay.
  - STEP: if advance, go to HALT when dbg_halt = 1, or RUN when dbg_halt = 0. While mem_stall, stay in STEP.
  - dbg_step outside HALT is ignored.
- Counters (wrap modulo 2^CNT_W):
  - cycle_cnt +1 every cycle with rst = 0.
  - retire_cnt +1 when advance & mem_valid.
  - stall_cnt +1 when mem_stall & state != HALT.

## Timing
- Reset:
  - During rst: state = RUN; counters = 0; all *_rst = 1; all *_en = 0.
  - Forward selects stay combinational during rst.
  - After rst falls, the first cycle has all enables = 1 (unless a stall is present).
- Latency:
  - Stage controls and forward selects are combinational from the current inputs and state.
  - State and counters update at posedge clk.
  - dbg_halt asserted in cycle N: enables in cycle N are still 1; frozen from N+1.
  - A dbg_step pulse in HALT gives exactly one advancing cycle, absent a mem stall.
- Boundary cases:
  - rst mid-stall or mid-halt aborts immediately.
  - mem_stall and branch_pending together: freeze wins, id_rst = 0, so no flush while frozen.
  - mem_ack high without an access is ignored.
  - A back-to-back branch in ID while another is in MEM: the IF load is still enabled by is_branch_mem, and ID is bubbled.

## Test plan
- Reset, then rs = rt = 0 and no stalls → all *_en = 1, all *_rst = 0, forward selects 0; cycle_cnt = 5 after 5 cycles.
- inst_data_id rs = 8; EXE writes r8 with wb_data_src_exe = 0 → exe_fwd_a_ctrl = 1. The same with a load → 3. EXE writes r9 and MEM writes r8 → 2. rs = 0 with an EXE write to r0 → 0.
- branch_id = 1 in cycle 0, moving to EXE in cycle 1 and MEM in cycle 2 → if_en = 0,0,1 and id_rst = 1,1,1 across cycles 0–2.
- mem_ren = 1 with mem_ack low for 3 cycles → all en = 0 and wb_rst = 0 for 3 cycles; stall_cnt = 3; retire_cnt unchanged.
- dbg_halt = 1 → halted = 1 next cycle with enables 0. A dbg_step pulse → exactly one cycle of enables = 1, retire_cnt +1 if mem_valid. Release halt → RUN.
- Assert rst during STEP with a pending mem stall → state RUN, counters 0, all rsts 1.

Source files
------------

// File: rtl/pipeline_sequencer_if.sv
// Control bundle between the MIPS datapath and its stage sequencer.
// The datapath side (master) supplies stage status; the sequencer (slave) returns stage controls.
interface pipeline_sequencer_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      inst_data_id;
    logic             branch_id;
    logic             is_branch_exe;
    logic             is_branch_mem;
    logic [4:0]       regw_addr_exe;
    logic [4:0]       regw_addr_mem;
    logic             wb_wen_exe;
    logic             wb_wen_mem;
    logic             wb_data_src_exe;
    logic             mem_valid;
    logic             mem_ren;
    logic             mem_wen;
    logic             mem_ack;
    logic             dbg_halt;
    logic             dbg_step;
    logic             if_rst;
    logic             if_en;
    logic             id_rst;
    logic             id_en;
    logic             exe_rst;
    logic             exe_en;
    logic             mem_rst;
    logic             mem_en;
    logic             wb_rst;
    logic             wb_en;
    logic [1:0]       exe_fwd_a_ctrl;
    logic [1:0]       exe_fwd_b_ctrl;
    logic             halted;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] retire_cnt;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output inst_data_id, branch_id, is_branch_exe, is_branch_mem,
               regw_addr_exe, regw_addr_mem, wb_wen_exe, wb_wen_mem, wb_data_src_exe,
               mem_valid, mem_ren, mem_wen, mem_ack, dbg_halt, dbg_step,
        input  if_rst, if_en, id_rst, id_en, exe_rst, exe_en, mem_rst, mem_en, wb_rst, wb_en,
               exe_fwd_a_ctrl, exe_fwd_b_ctrl, halted, cycle_cnt, retire_cnt, stall_cnt
    );

    modport slave (
        input  inst_data_id, branch_id, is_branch_exe, is_branch_mem,
               regw_addr_exe, regw_addr_mem, wb_wen_exe, wb_wen_mem, wb_data_src_exe,
               mem_valid, mem_ren, mem_wen, mem_ack, dbg_halt, dbg_step,
        output if_rst, if_en, id_rst, id_en, exe_rst, exe_en, mem_rst, mem_en, wb_rst, wb_en,
               exe_fwd_a_ctrl, exe_fwd_b_ctrl, halted, cycle_cnt, retire_cnt, stall_cnt
    );
endinterface

// File: rtl/pipeline_sequencer.sv
// Stage sequencer and hazard controller for the 5-stage MIPS pipeline: stage enables and flushes,
// memory-stall freeze, EXE forwarding selects, debug run/halt/step and performance counters.
module pipeline_sequencer #(
    parameter int CNT_W = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    pipeline_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic             r_halted;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_retire_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic             w_mem_stall;
    logic             w_advance;
    logic             w_branch_pending;
    logic             w_run;
    logic [4:0]       w_rs;
    logic [4:0]       w_rt;
    logic             w_unused;

    // An EXE producer is younger than a MEM producer, so its match wins.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] field,
        input logic       wen_exe,
        input logic [4:0] addr_exe,
        input logic       load_exe,
        input logic       wen_mem,
        input logic [4:0] addr_mem
    );
        logic [1:0] sel;
        if (field == 5'd0) begin
            sel = 2'd0;
        end else if (wen_exe && (addr_exe == field)) begin
            sel = load_exe ? 2'd3 : 2'd1;
        end else if (wen_mem && (addr_mem == field)) begin
            sel = 2'd2;
        end else begin
            sel = 2'd0;
        end
        return sel;
    endfunction

    assign w_rs             = bus.inst_data_id[25:21];
    assign w_rt             = bus.inst_data_id[20:16];
    assign w_unused         = &{1'b0, bus.inst_data_id[31:26], bus.inst_data_id[15:0]};
    assign w_mem_stall      = (bus.mem_ren | bus.mem_wen) & ~bus.mem_ack;
    assign w_advance        = (r_state != ST_HALT) & ~w_mem_stall;
    assign w_branch_pending = bus.branch_id | bus.is_branch_exe | bus.is_branch_mem;
    assign w_run            = w_advance & ~i_rst;

    // The PC holds while a branch sits in ID/EXE and loads the target once it reaches MEM.
    assign bus.if_rst  = i_rst;
    assign bus.id_rst  = i_rst | (w_advance & w_branch_pending);
    assign bus.exe_rst = i_rst;
    assign bus.mem_rst = i_rst;
    assign bus.wb_rst  = i_rst;
    assign bus.if_en   = w_run & (~w_branch_pending | bus.is_branch_mem);
    assign bus.id_en   = w_run;
    assign bus.exe_en  = w_run;
    assign bus.mem_en  = w_run;
    assign bus.wb_en   = w_run;

    assign bus.exe_fwd_a_ctrl = fwd_sel(w_rs, bus.wb_wen_exe, bus.regw_addr_exe, bus.wb_data_src_exe,
                                        bus.wb_wen_mem, bus.regw_addr_mem);
    assign bus.exe_fwd_b_ctrl = fwd_sel(w_rt, bus.wb_wen_exe, bus.regw_addr_exe, bus.wb_data_src_exe,
                                        bus.wb_wen_mem, bus.regw_addr_mem);

    assign bus.halted     = r_halted;
    assign bus.cycle_cnt  = r_cycle_cnt;
    assign bus.retire_cnt = r_retire_cnt;
    assign bus.stall_cnt  = r_stall_cnt;

    // Debug run/halt/step machine; a step stays pending until its cycle actually advances.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (bus.dbg_halt) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end else begin
                        r_state  <= ST_RUN;
                        r_halted <= 1'b0;
                    end
                end
                ST_HALT: begin
                    if (!bus.dbg_halt) begin
                        r_state  <= ST_RUN;
                        r_halted <= 1'b0;
                    end else if (bus.dbg_step) begin
                        r_state  <= ST_STEP;
                        r_halted <= 1'b0;
                    end else begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end
                end
                ST_STEP: begin
                    if (w_mem_stall) begin
                        r_state  <= ST_STEP;
                        r_halted <= 1'b0;
                    end else if (bus.dbg_halt) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end else begin
                        r_state  <= ST_RUN;
                        r_halted <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_RUN;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    // Performance counters; stalls are not counted while halted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cycle_cnt  <= {CNT_W{1'b0}};
            r_retire_cnt <= {CNT_W{1'b0}};
            r_stall_cnt  <= {CNT_W{1'b0}};
        end else begin
            r_cycle_cnt <= r_cycle_cnt + CNT_ONE;
            if (w_advance && bus.mem_valid) begin
                r_retire_cnt <= r_retire_cnt + CNT_ONE;
            end else begin
                r_retire_cnt <= r_retire_cnt;
            end
            if (w_mem_stall && (r_state != ST_HALT)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
        end
    end
endmodule
